// File: rtl/spi_defs.sv
// -----------------------------------------------------------------------------
// spi_defs
// Shared definitions for the SPI master and its CPU-side instantiation:
//   - spi_state_e : controller state encoding
//   - SPI_MODE0-3 : SPI modes packed as {cpol, cpha}
//   - W_SPI_DATA  : default transfer width used by the CPU integration
//   - W_SPI_DIV   : default clock-divider setting width
// -----------------------------------------------------------------------------
package spi_defs;

  localparam int unsigned W_SPI_DATA = 8;
  localparam int unsigned W_SPI_DIV  = 8;

  // Transfer sequencing: chip-select setup, shifting, chip-select hold, writeback
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Half-period timer for the SPI master. While en is high it emits a registered
// one-cycle tick every H = div+1 clk cycles. While en is low the count is held
// at zero, so every rising edge of en starts a fresh, full half-period.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   en       : run the timer
//   div      : half-period setting (H = div+1)
//   tick     : one-cycle pulse at the end of each half-period
// -----------------------------------------------------------------------------
module spi_clk_div
  #(
    parameter int unsigned W_DIV = 8
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W_DIV-1:0] div,
    output logic             tick
  );

  // One extra bit so that div all-ones gives H = 2^W_DIV without wrapping
  localparam int unsigned W_CNT = W_DIV + 1;

  logic [W_CNT-1:0] cnt;
  logic [W_CNT-1:0] half_c;
  logic             wrap_c;

  assign half_c = W_CNT'(div) + W_CNT'(1);
  assign wrap_c = (cnt + W_CNT'(1)) == half_c;

  // Up-counter over one half-period; tick is registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (wrap_c) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + W_CNT'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI master for the CPU peripheral bus. Shifts one W_DATA-bit word MSB-first
// in all four CPOL/CPHA modes with a programmable SCLK half-period, driving one
// of N_CS active-low chip selects. One transfer at a time; the received word is
// returned with a one-cycle rx_dv pulse.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   start             : transfer request, only honoured in IDLE
//   tx_data, cs_sel,
//   cpol, cpha,
//   clk_div           : transfer configuration, latched on an accepted start
//   busy              : transfer in progress (through the rx_dv cycle)
//   rx_data, rx_dv    : received word and its one-cycle valid pulse
//   sclk, mosi, miso  : SPI bus
//   cs_n              : active-low chip selects
// -----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_defs::*;
  #(
    parameter  int unsigned W_DATA = 8,
    parameter  int unsigned N_CS   = 2,
    parameter  int unsigned W_DIV  = 8,
    localparam int unsigned W_CS   = (N_CS > 1) ? $clog2(N_CS) : 1
  )
  (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_DATA-1:0] tx_data,
    input  logic [W_CS-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [W_DIV-1:0]  clk_div,
    output logic              busy,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_dv,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [N_CS-1:0]   cs_n
  );

  localparam int unsigned W_EDGE = $clog2(2 * W_DATA);
  localparam logic [W_EDGE-1:0] LAST_EDGE = W_EDGE'(2 * W_DATA - 1);

  spi_state_e        state;
  logic              cpol_q;
  logic              cpha_q;
  logic [W_DIV-1:0]  div_q;
  logic [W_DATA-1:0] tx_sr;
  logic [W_DATA-1:0] rx_sr;
  logic [W_EDGE-1:0] edge_cnt;
  logic              tick;

  logic              div_en_c;
  logic              cs_ok_c;
  logic              sample_c;
  logic              last_c;

  // Divider runs through the timed phases only
  assign div_en_c = (state == LEAD) || (state == XFER) || (state == TRAIL);

  // Out-of-range slave index is rejected rather than wrapped
  assign cs_ok_c = {1'b0, cs_sel} < (W_CS + 1)'(N_CS);

  // Even edge index = leading edge; CPHA picks which edge samples
  assign sample_c = cpha_q ? edge_cnt[0] : ~edge_cnt[0];
  assign last_c   = (edge_cnt == LAST_EDGE);

  spi_clk_div #(
    .W_DIV (W_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en_c),
    .div  (div_q),
    .tick (tick)
  );

  // Transfer sequencer; every output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_dv    <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
    end else begin
      rx_dv <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          sclk <= cpol_q;
          if (start && cs_ok_c) begin
            state    <= LEAD;
            busy     <= 1'b1;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            div_q    <= clk_div;
            sclk     <= cpol;
            cs_n     <= ~(N_CS'(1) << cs_sel);
            rx_sr    <= '0;
            edge_cnt <= '0;
            // CPHA=0 presents the MSB before the first (sampling) edge
            if (!cpha) begin
              mosi  <= tx_data[W_DATA-1];
              tx_sr <= tx_data << 1;
            end else begin
              tx_sr <= tx_data;
            end
          end
        end

        LEAD: begin
          if (tick) begin
            state <= XFER;
          end
        end

        XFER: begin
          if (tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + W_EDGE'(1);
            if (sample_c) begin
              rx_sr <= {rx_sr[W_DATA-2:0], miso};
            end else if (!last_c) begin
              // Only CPHA=0 ends on a drive edge; that one is suppressed
              mosi  <= tx_sr[W_DATA-1];
              tx_sr <= tx_sr << 1;
            end
            if (last_c) begin
              state <= TRAIL;
            end
          end
        end

        TRAIL: begin
          if (tick) begin
            state   <= DONE;
            cs_n    <= '1;
            rx_data <= rx_sr;
            rx_dv   <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cs_n  <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl. Stimulus pushes the expected word and
// latency for each transfer into a queue; a monitor on the falling clock edge
// pops it whenever rx_dv is seen and also watches cs_n, SCLK edge count and
// MOSI change timing during every transfer.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;
  import spi_defs::*;

  localparam int unsigned W   = W_SPI_DATA;
  localparam int unsigned WD  = W_SPI_DIV;
  localparam int unsigned NCS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  tx_data;
  logic [1:0]    cs_sel;
  logic          cpol;
  logic          cpha;
  logic [WD-1:0] clk_div;
  logic          busy;
  logic [W-1:0]  rx_data;
  logic          rx_dv;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic [NCS-1:0] cs_n;

  spi_master_ctrl #(
    .W_DATA (W),
    .N_CS   (NCS),
    .W_DIV  (WD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .cs_sel  (cs_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .clk_div (clk_div),
    .busy    (busy),
    .rx_data (rx_data),
    .rx_dv   (rx_dv),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  t0;
    int unsigned  lat;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Per-transfer context seen by monitor and slave model
  logic       cur_cpol = 1'b0;
  logic       cur_cpha = 1'b0;
  logic [1:0] cur_cs   = 2'd0;
  logic       loop     = 1'b1;
  logic [W-1:0] slave_word = '0;
  logic       slave_bit = 1'b0;
  int         slave_idx = 0;

  assign miso = loop ? mosi : slave_bit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [NCS-1:0] cs_exp(input logic [1:0] c);
    logic [NCS-1:0] one;
    one = NCS'(1);
    return ~(one << c);
  endfunction

  // Slave model for CPHA=1: presents the next bit on each leading SCLK edge
  always @(sclk, cs_n) begin
    if (cs_n == '1) begin
      slave_idx = 0;
    end else if (!loop && sclk != cur_cpol && slave_idx < int'(W)) begin
      slave_bit = slave_word[W-1-slave_idx];
      slave_idx++;
    end
  end

  // Monitor
  logic           prev_sclk = 1'b0;
  logic           prev_mosi = 1'b0;
  logic [NCS-1:0] prev_cs   = '1;
  int             edges     = 0;

  always @(negedge clk) begin
    if (rst) begin
      edges = 0;
    end else begin
      if (prev_cs != '1) begin
        if (sclk != prev_sclk) edges++;
        if (mosi != prev_mosi)
          chk("mosi_timing", 32'((sclk != prev_sclk) && ((sclk == cur_cpol) != cur_cpha)), 32'd1);
        if (cs_n != '1)
          chk("cs_n_active", 32'(cs_n), 32'(cs_exp(cur_cs)));
      end
      if (rx_dv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_dv", 32'(rx_dv), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.data));
          chk("latency", cyc - e.t0, e.lat);
          chk("sclk_edges", 32'(edges), 32'(2 * W));
          chk("busy_at_dv", 32'(busy), 32'd1);
          chk("cs_n_at_dv", 32'(cs_n), 32'h7);
        end
        edges = 0;
      end
    end
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_cs   = rst ? '1 : cs_n;
  end

  task automatic begin_xfer(input logic [1:0] mode, input logic [W-1:0] data,
                            input logic [1:0] cs, input logic [WD-1:0] div,
                            input logic lb, input logic [W-1:0] slv,
                            input logic [W-1:0] exp_rx, output int unsigned t0);
    @(negedge clk);
    cur_cpol   = mode[1];
    cur_cpha   = mode[0];
    cur_cs     = cs;
    loop       = lb;
    slave_word = slv;
    {cpol, cpha} = mode;
    tx_data    = data;
    cs_sel     = cs;
    clk_div    = div;
    start      = 1'b1;
    t0         = cyc + 1;
    exp_q.push_back('{data: exp_rx, t0: t0, lat: (2 * W + 2) * (int'(div) + 1) + 1});
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs; the latched configuration must carry the transfer
    tx_data      = ~data;
    cs_sel       = cs + 2'd1;
    clk_div      = div ^ WD'(1);
    {cpol, cpha} = ~mode;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("sclk_lead", 32'(sclk), 32'(mode[1]));
    chk("cs_n_lead", 32'(cs_n), 32'(cs_exp(cs)));
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge clk);
    chk({nm, "_done"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected end before it", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    rst = 1'b1; start = 1'b0; tx_data = '0; cs_sel = '0;
    cpol = 1'b0; cpha = 1'b0; clk_div = '0;
    #1;
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_rx_dv",   32'(rx_dv),   32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_sclk",    32'(sclk),    32'd0);
    chk("rst_mosi",    32'(mosi),    32'd0);
    chk("rst_cs_n",    32'(cs_n),    32'h7);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Mode 0 loopback, H=2
    begin_xfer(SPI_MODE0, 8'hA5, 2'd0, 8'd1, 1'b1, 8'h00, 8'hA5, t0);
    wait_done("mode0");

    // Mode 3, H=1, slave drives 0x3C
    begin_xfer(SPI_MODE3, 8'h0F, 2'd1, 8'd0, 1'b0, 8'h3C, 8'h3C, t0);
    wait_done("mode3");
    chk("mode3_sclk_idle", 32'(sclk), 32'd1);

    // Modes 1 and 2 loopback
    begin_xfer(SPI_MODE1, 8'h81, 2'd0, 8'd2, 1'b1, 8'h00, 8'h81, t0);
    wait_done("mode1");
    begin_xfer(SPI_MODE2, 8'h81, 2'd2, 8'd1, 1'b1, 8'h00, 8'h81, t0);
    wait_done("mode2");
    chk("mode2_sclk_idle", 32'(sclk), 32'd1);

    // Restart attempts during a transfer are ignored
    begin_xfer(SPI_MODE0, 8'h96, 2'd0, 8'd1, 1'b1, 8'h00, 8'h96, t0);
    while (cyc < t0 + 5) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart");
    repeat (50) @(negedge clk);
    chk("restart_quiet_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-transfer
    begin_xfer(SPI_MODE0, 8'h77, 2'd0, 8'd1, 1'b1, 8'h00, 8'h77, t0);
    while (cyc < t0 + 10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n",    32'(cs_n),    32'h7);
    chk("abort_busy",    32'(busy),    32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    chk("abort_rx_dv",   32'(rx_dv),   32'd0);
    chk("abort_sclk",    32'(sclk),    32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_quiet_busy", 32'(busy), 32'd0);
    begin_xfer(SPI_MODE0, 8'h5A, 2'd0, 8'd1, 1'b1, 8'h00, 8'h5A, t0);
    wait_done("after_abort");

    // Out-of-range chip select is ignored
    @(negedge clk);
    cs_sel = 2'd3; tx_data = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bad_cs_busy", 32'(busy), 32'd0);
      chk("bad_cs_cs_n", 32'(cs_n), 32'h7);
      @(negedge clk);
    end

    // Largest divider: H = 256
    begin_xfer(SPI_MODE0, 8'hC3, 2'd0, 8'd255, 1'b1, 8'h00, 8'hC3, t0);
    wait_done("div255");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
